// File: rtl/spwl_tx_arbiter.sv
// spwl_tx_arbiter: packet-granular round-robin arbiter in front of the
// SpaceWire Light TX byte port. Each packet passes through whole, with no
// added latency. A stalled owner is aborted with an EEP by a watchdog.
// Requesters that were cut off are flushed up to and including their next
// EOP/EEP byte.
module spwl_tx_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_IDLE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_run,
    input  logic [NREQ-1:0]   req_txwrite,
    input  logic [NREQ-1:0]   req_txflag,
    input  logic [8*NREQ-1:0] req_txdata,
    output logic [NREQ-1:0]   req_txrdy,
    output logic              txwrite,
    output logic              txflag,
    output logic [7:0]        txdata,
    input  logic              txrdy,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   drop_pend,
    output logic [15:0]       abort_count
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_IDLE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_EEP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              started_q, started_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   drop_q;
    logic [NREQ-1:0]   drop_set;
    logic [NREQ-1:0]   drop_clr;
    logic [15:0]       abort_q;
    logic              abort_inc;

    logic [NREQ-1:0]   elig;
    logic              pick_ok;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              xfer;

    // Abort counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign grant       = grant_q;
    assign drop_pend   = drop_q;
    assign abort_count = abort_q;

    assign xfer     = txwrite & txrdy;
    assign elig     = req_txwrite & ~drop_q & {NREQ{link_run}};
    // A flushed requester always sees req_txrdy=1, so its flag byte is consumed now.
    assign drop_clr = drop_q & req_txwrite & req_txflag;

    // Round-robin pick: scan downward so the candidate right after 'last' wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NREQ);
            if (elig[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Core-side and requester-side handshakes: a zero-latency mux for the owner, the EEP in abort.
    always_comb begin
        txwrite   = 1'b0;
        txflag    = 1'b0;
        txdata    = 8'h00;
        req_txrdy = drop_q;
        case (state_q)
            S_PASS: begin
                txwrite            = req_txwrite[owner_q];
                txflag             = req_txflag[owner_q];
                txdata             = req_txdata[8*owner_q +: 8];
                req_txrdy[owner_q] = txrdy;
            end
            S_EEP: begin
                txwrite            = 1'b1;
                txflag             = 1'b1;
                txdata             = 8'h01;
                req_txrdy[owner_q] = 1'b0;
            end
            default: ;
        endcase
    end

    // Next-state: grant selection, end of packet, link loss and watchdog abort.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        started_d = started_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        drop_set  = '0;
        abort_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    state_d   = S_PASS;
                    owner_d   = pick_idx;
                    last_d    = pick_idx;
                    grant_d   = NREQ'(1) << pick_idx;
                    started_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_PASS: begin
                started_d = started_q | xfer;
                // Only owner-side stalls count; core back-pressure is never the owner's fault.
                if (xfer)
                    cnt_d = '0;
                else if (!req_txwrite[owner_q] && txrdy)
                    cnt_d = cnt_q + CNT_W'(1);
                // End of packet has priority over link loss and over the watchdog.
                if (xfer && txflag) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (!link_run) begin
                    // The core drops its own buffer on link loss; only the source needs flushing.
                    state_d = S_IDLE;
                    grant_d = '0;
                    if (started_d)
                        drop_set[owner_q] = 1'b1;
                end else if (cnt_d == CNT_W'(MAX_IDLE)) begin
                    state_d = S_EEP;
                end
            end
            S_EEP: begin
                if (!link_run) begin
                    state_d           = S_IDLE;
                    grant_d           = '0;
                    drop_set[owner_q] = 1'b1;
                end else if (txrdy) begin
                    state_d           = S_IDLE;
                    grant_d           = '0;
                    drop_set[owner_q] = 1'b1;
                    abort_inc         = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register. Reset abandons any packet in flight without an EEP or a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            started_q <= 1'b0;
            cnt_q     <= '0;
            grant_q   <= '0;
            drop_q    <= '0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            started_q <= started_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            drop_q    <= (drop_q & ~drop_clr) | drop_set;
            if (abort_inc)
                abort_q <= sat_inc16(abort_q);
        end
    end

endmodule

// File: tb/tb_spwl_tx_arbiter.sv
// Directed bench for spwl_tx_arbiter (NREQ=2, MAX_IDLE=8). Each row gives one
// cycle of inputs and the outputs expected during that cycle.
module tb_spwl_tx_arbiter;

    localparam int NREQ     = 2;
    localparam int MAX_IDLE = 8;

    logic              clk;
    logic              rst;
    logic              link_run;
    logic [NREQ-1:0]   req_txwrite;
    logic [NREQ-1:0]   req_txflag;
    logic [8*NREQ-1:0] req_txdata;
    logic [NREQ-1:0]   req_txrdy;
    logic              txwrite;
    logic              txflag;
    logic [7:0]        txdata;
    logic              txrdy;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   drop_pend;
    logic [15:0]       abort_count;

    int checks   = 0;
    int failures = 0;

    spwl_tx_arbiter #(.NREQ(NREQ), .MAX_IDLE(MAX_IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .link_run    (link_run),
        .req_txwrite (req_txwrite),
        .req_txflag  (req_txflag),
        .req_txdata  (req_txdata),
        .req_txrdy   (req_txrdy),
        .txwrite     (txwrite),
        .txflag      (txflag),
        .txdata      (txdata),
        .txrdy       (txrdy),
        .grant       (grant),
        .drop_pend   (drop_pend),
        .abort_count (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       link;
        logic [1:0] wr;
        logic [1:0] fl;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       ewr;
        logic       efl;
        logic [7:0] ed;
        logic [1:0] egnt;
        logic [1:0] erdy;
        logic [1:0] edrop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic l,
                                input logic [1:0] w, input logic [1:0] f,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic rd, input logic ewr, input logic efl,
                                input logic [7:0] ed, input logic [1:0] eg,
                                input logic [1:0] er, input logic [1:0] edr);
        vec_t v;
        v.rst = r;  v.link = l;  v.wr = w;  v.fl = f;  v.d0 = a;  v.d1 = b;
        v.rdy = rd; v.ewr = ewr; v.efl = efl; v.ed = ed;
        v.egnt = eg; v.erdy = er; v.edrop = edr;
        return v;
    endfunction

    task automatic cyc(input vec_t v, input string name);
        logic [15:0] act;
        logic [15:0] exp;
        @(negedge clk);
        rst         = v.rst;
        link_run    = v.link;
        req_txwrite = v.wr;
        req_txflag  = v.fl;
        req_txdata  = {v.d1, v.d0};
        txrdy       = v.rdy;
        #2;
        act = {txwrite, txflag, txdata, grant, req_txrdy, drop_pend};
        exp = {v.ewr, v.efl, v.ed, v.egnt, v.erdy, v.edrop};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got wr=%b fl=%b d=%02h gnt=%b rdy=%b drop=%b, want wr=%b fl=%b d=%02h gnt=%b rdy=%b drop=%b",
                     name, $time, txwrite, txflag, txdata, grant, req_txrdy, drop_pend,
                     v.ewr, v.efl, v.ed, v.egnt, v.erdy, v.edrop);
        end
    endtask

    task automatic chk_abort(input logic [15:0] want, input string name);
        checks++;
        if (abort_count !== want) begin
            failures++;
            $display("FAIL %s: abort_count got %0d want %0d", name, abort_count, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; link_run = 1'b1; req_txwrite = '0; req_txflag = '0;
        req_txdata = '0; txrdy = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then two simultaneous 3-byte packets, then 1-byte round robin.
        tbl.push_back(mk(1,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,1,2'b11,2'b00,8'hA0,8'hB0,1, 0,0,8'h00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,1,2'b11,2'b00,8'hA0,8'hB0,1, 1,0,8'hA0,2'b01,2'b01,2'b00));
        tbl.push_back(mk(0,1,2'b11,2'b00,8'hA1,8'hB0,1, 1,0,8'hA1,2'b01,2'b01,2'b00));
        tbl.push_back(mk(0,1,2'b11,2'b01,8'h00,8'hB0,1, 1,1,8'h00,2'b01,2'b01,2'b00));
        tbl.push_back(mk(0,1,2'b10,2'b00,8'h00,8'hB0,1, 0,0,8'h00,2'b00,2'b00,2'b00));
        tbl.push_back(mk(0,1,2'b10,2'b00,8'h00,8'hB0,1, 1,0,8'hB0,2'b10,2'b10,2'b00));
        tbl.push_back(mk(0,1,2'b10,2'b00,8'h00,8'hB1,1, 1,0,8'hB1,2'b10,2'b10,2'b00));
        tbl.push_back(mk(0,1,2'b10,2'b10,8'h00,8'h00,1, 1,1,8'h00,2'b10,2'b10,2'b00));
        tbl.push_back(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(0,1,2'b11,2'b11,8'h0A,8'h0B,1, 0,0,8'h00,2'b00,2'b00,2'b00));
            tbl.push_back(mk(0,1,2'b11,2'b11,8'h0A,8'h0B,1, 1,1,8'h0A,2'b01,2'b01,2'b00));
            tbl.push_back(mk(0,1,2'b11,2'b11,8'h0A,8'h0B,1, 0,0,8'h00,2'b00,2'b00,2'b00));
            tbl.push_back(mk(0,1,2'b11,2'b11,8'h0A,8'h0B,1, 1,1,8'h0B,2'b10,2'b10,2'b00));
        end
        tbl.push_back(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i], $sformatf("table_row%0d", i));
            if (i == 0) chk_abort(16'd0, "reset_abort");
        end

        // Watchdog: one byte, MAX_IDLE stall cycles, EEP, then flush of the late bytes.
        cyc(mk(0,1,2'b01,2'b00,8'h11,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "wdog_idle");
        cyc(mk(0,1,2'b01,2'b00,8'h11,8'h00,1, 1,0,8'h11,2'b01,2'b01,2'b00), "wdog_byte");
        for (int i = 0; i < MAX_IDLE; i++)
            cyc(mk(0,1,2'b10,2'b00,8'h00,8'h22,1, 0,0,8'h00,2'b01,2'b01,2'b00), "wdog_stall");
        cyc(mk(0,1,2'b10,2'b00,8'h00,8'h22,1, 1,1,8'h01,2'b01,2'b00,2'b00), "wdog_eep");
        cyc(mk(0,1,2'b11,2'b00,8'h33,8'h22,1, 0,0,8'h00,2'b00,2'b01,2'b01), "wdog_after");
        chk_abort(16'd1, "wdog_abort");
        cyc(mk(0,1,2'b11,2'b00,8'h34,8'h22,1, 1,0,8'h22,2'b10,2'b11,2'b01), "wdog_other_b0");
        cyc(mk(0,1,2'b11,2'b11,8'h35,8'h00,1, 1,1,8'h00,2'b10,2'b11,2'b01), "wdog_other_eop");
        cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "wdog_cleared");
        chk_abort(16'd1, "wdog_abort_hold");

        // Core back-pressure for 3*MAX_IDLE cycles, plus owner stalls while txrdy=0: no abort.
        cyc(mk(0,1,2'b01,2'b00,8'h40,8'h00,0, 0,0,8'h00,2'b00,2'b00,2'b00), "bp_idle");
        for (int i = 0; i < 3*MAX_IDLE; i++)
            cyc(mk(0,1,2'b01,2'b00,8'h40,8'h00,0, 1,0,8'h40,2'b01,2'b00,2'b00), "bp_hold");
        for (int i = 0; i < MAX_IDLE + 2; i++)
            cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,0, 0,0,8'h00,2'b01,2'b00,2'b00), "bp_owner_gap");
        cyc(mk(0,1,2'b01,2'b00,8'h40,8'h00,1, 1,0,8'h40,2'b01,2'b01,2'b00), "bp_b0");
        cyc(mk(0,1,2'b01,2'b01,8'h41,8'h00,1, 1,1,8'h41,2'b01,2'b01,2'b00), "bp_eop");
        cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "bp_done");
        chk_abort(16'd1, "bp_abort");

        // Link loss after two bytes: flush, no EEP, no grant until link returns.
        cyc(mk(0,1,2'b01,2'b00,8'h50,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "link_idle");
        cyc(mk(0,1,2'b01,2'b00,8'h50,8'h00,1, 1,0,8'h50,2'b01,2'b01,2'b00), "link_b0");
        cyc(mk(0,1,2'b01,2'b00,8'h51,8'h00,1, 1,0,8'h51,2'b01,2'b01,2'b00), "link_b1");
        cyc(mk(0,0,2'b01,2'b00,8'h52,8'h00,0, 1,0,8'h52,2'b01,2'b00,2'b00), "link_fall");
        cyc(mk(0,0,2'b11,2'b00,8'h52,8'h60,1, 0,0,8'h00,2'b00,2'b01,2'b01), "link_down0");
        cyc(mk(0,0,2'b11,2'b00,8'h53,8'h60,1, 0,0,8'h00,2'b00,2'b01,2'b01), "link_down1");
        cyc(mk(0,1,2'b11,2'b01,8'h54,8'h60,1, 0,0,8'h00,2'b00,2'b01,2'b01), "link_back");
        cyc(mk(0,1,2'b10,2'b00,8'h00,8'h60,1, 1,0,8'h60,2'b10,2'b10,2'b00), "link_r1_b0");
        cyc(mk(0,1,2'b10,2'b10,8'h00,8'h61,1, 1,1,8'h61,2'b10,2'b10,2'b00), "link_r1_eop");
        cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "link_done");
        chk_abort(16'd1, "link_abort");

        // Reset mid-packet: silent abandon, outputs zero, requester 0 first again.
        cyc(mk(0,1,2'b01,2'b00,8'h70,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "rst_idle");
        cyc(mk(0,1,2'b01,2'b00,8'h70,8'h00,1, 1,0,8'h70,2'b01,2'b01,2'b00), "rst_b0");
        cyc(mk(1,1,2'b01,2'b00,8'h71,8'h00,1, 1,0,8'h71,2'b01,2'b01,2'b00), "rst_assert");
        cyc(mk(0,1,2'b11,2'b00,8'h80,8'h90,1, 0,0,8'h00,2'b00,2'b00,2'b00), "rst_after");
        chk_abort(16'd0, "rst_abort");
        cyc(mk(0,1,2'b11,2'b00,8'h80,8'h90,1, 1,0,8'h80,2'b01,2'b01,2'b00), "rst_r0_first");
        cyc(mk(0,1,2'b01,2'b01,8'h81,8'h00,1, 1,1,8'h81,2'b01,2'b01,2'b00), "rst_r0_eop");
        cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "rst_done");

        // MAX_IDLE-1 stalls then an EOP: the packet ends normally with no abort.
        cyc(mk(0,1,2'b01,2'b00,8'hC0,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "edge_idle");
        cyc(mk(0,1,2'b01,2'b00,8'hC0,8'h00,1, 1,0,8'hC0,2'b01,2'b01,2'b00), "edge_b0");
        for (int i = 0; i < MAX_IDLE - 1; i++)
            cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b01,2'b01,2'b00), "edge_stall");
        cyc(mk(0,1,2'b01,2'b01,8'hC1,8'h00,1, 1,1,8'hC1,2'b01,2'b01,2'b00), "edge_eop");
        cyc(mk(0,1,2'b00,2'b00,8'h00,8'h00,1, 0,0,8'h00,2'b00,2'b00,2'b00), "edge_done");
        chk_abort(16'd0, "edge_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
